// File: rtl/decode_queue.sv
// RV32I decoder feeding a DEPTH-entry FIFO of decoded bundles between fetch and execute.
// Optional retire/illegal statistics counters are enabled with `define DECODE_QUEUE_STATS_EN.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                instruction,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [6:0]                 opcode,
    output logic [2:0]                 funct3,
    output logic [6:0]                 funct7,
    output logic [4:0]                 rs1,
    output logic [4:0]                 rs2,
    output logic [4:0]                 rd,
    output logic [XLEN-1:0]            imm,
    output logic                       alu_src,
    output logic [2:0]                 fmt,
    output logic                       illegal,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef DECODE_QUEUE_STATS_EN
    ,
    output logic [31:0]                retired_cnt,
    output logic [15:0]                illegal_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            alu_src;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    // Full decode of one instruction word; illegal encodings keep only the opcode.
    function automatic entry_t decode(input logic [31:0] i);
        entry_t     e;
        logic [31:0] imm32;
        logic        bad;
        e      = '0;
        imm32  = 32'd0;
        bad    = 1'b0;
        e.opcode = i[6:0];
        case (i[6:0])
            7'b0110011: begin
                e.funct3 = i[14:12];
                e.funct7 = i[31:25];
                e.rs1    = i[19:15];
                e.rs2    = i[24:20];
                e.rd     = i[11:7];
                e.fmt    = FMT_R;
                bad      = (i[31:25] != 7'b0000000) && (i[31:25] != 7'b0100000);
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                e.funct3  = i[14:12];
                e.rs1     = i[19:15];
                e.rd      = i[11:7];
                // Shift-immediates carry funct7 to distinguish SRLI from SRAI.
                if ((i[6:0] == 7'b0010011) && ((i[14:12] == 3'b001) || (i[14:12] == 3'b101))) begin
                    e.funct7 = i[31:25];
                end else begin
                    e.funct7 = 7'd0;
                end
                imm32     = {{20{i[31]}}, i[31:20]};
                e.alu_src = 1'b1;
                e.fmt     = FMT_I;
            end
            7'b0100011: begin
                e.funct3  = i[14:12];
                e.rs1     = i[19:15];
                e.rs2     = i[24:20];
                imm32     = {{20{i[31]}}, i[31:25], i[11:7]};
                e.alu_src = 1'b1;
                e.fmt     = FMT_S;
            end
            7'b1100011: begin
                e.funct3  = i[14:12];
                e.rs1     = i[19:15];
                e.rs2     = i[24:20];
                imm32     = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
                e.fmt     = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                e.rd      = i[11:7];
                imm32     = {i[31:12], 12'd0};
                e.alu_src = 1'b1;
                e.fmt     = FMT_U;
            end
            7'b1101111: begin
                e.rd      = i[11:7];
                imm32     = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
                e.alu_src = 1'b1;
                e.fmt     = FMT_J;
            end
            default: begin
                bad = 1'b1;
            end
        endcase
        e.imm = XLEN'($signed(imm32));
        if (bad || (i[1:0] != 2'b11)) begin
            e         = '0;
            e.opcode  = i[6:0];
            e.fmt     = FMT_ILL;
            e.illegal = 1'b1;
        end else begin
            e.illegal = 1'b0;
        end
        return e;
    endfunction

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    entry_t             dec_s;
    entry_t             head_s;
    logic               push_s;
    logic               pop_s;

    assign dec_s     = decode(instruction);
    assign in_ready  = (level_q < LVL_W'(DEPTH));
    assign out_valid = (level_q != LVL_W'(0));
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign level     = level_q;

    // Next-state for pointers, occupancy and storage; flush wins over push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = dec_s;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

    // Head entry, forced to zero whenever nothing is valid.
    always_comb begin
        head_s = '0;
        if (out_valid) begin
            head_s = mem_q[rd_ptr_q];
        end else begin
            head_s = '0;
        end
    end

    assign opcode  = head_s.opcode;
    assign funct3  = head_s.funct3;
    assign funct7  = head_s.funct7;
    assign rs1     = head_s.rs1;
    assign rs2     = head_s.rs2;
    assign rd      = head_s.rd;
    assign imm     = head_s.imm;
    assign alu_src = head_s.alu_src;
    assign fmt     = head_s.fmt;
    assign illegal = head_s.illegal;

`ifdef DECODE_QUEUE_STATS_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;
    logic [15:0] illegal_cnt_q, illegal_cnt_d;
    logic        retire_s;

    // Entries discarded by flush are not counted as retired.
    assign retire_s = pop_s && !flush;

    // Saturating statistics counters.
    always_comb begin
        retired_cnt_d = retired_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (retire_s && (retired_cnt_q != 32'hFFFF_FFFF)) begin
            retired_cnt_d = retired_cnt_q + 32'd1;
        end else begin
            retired_cnt_d = retired_cnt_q;
        end
        if (retire_s && head_s.illegal && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
        end else begin
            illegal_cnt_d = illegal_cnt_q;
        end
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt_q <= 32'd0;
            illegal_cnt_q <= 16'd0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Directed scoreboard bench for decode_queue (XLEN=32, DEPTH=2): hand-decoded expected bundles.
module tb_decode_queue;

    typedef logic [68:0] bundle_t;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        alu_src;
    logic [2:0]  fmt;
    logic        illegal;
    logic [1:0]  level;
`ifdef DECODE_QUEUE_STATS_EN
    logic [31:0] retired_cnt;
    logic [15:0] illegal_cnt;
`endif

    int      n_assert = 0;
    int      n_fail   = 0;
    int      exp_lvl  = 0;
    bundle_t sb[$];

    decode_queue #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm(imm), .alu_src(alu_src), .fmt(fmt), .illegal(illegal), .level(level)
`ifdef DECODE_QUEUE_STATS_EN
        , .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bundle_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                                   input logic [31:0] im, input logic a, input logic [2:0] f,
                                   input logic il);
        return {op, f3, f7, s1, s2, d, im, a, f, il};
    endfunction

    function automatic bundle_t obs();
        return {opcode, funct3, funct7, rs1, rs2, rd, imm, alu_src, fmt, illegal};
    endfunction

    task automatic chk(input string tag, input bundle_t o, input bundle_t e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One cycle: drive at negedge, check handshake/level and any pop, update the model, advance.
    task automatic tick(input logic [31:0] ins, input logic iv, input logic ordy,
                        input logic fl, input bundle_t e);
        logic push;
        logic pop;
        instruction = ins;
        in_valid    = iv;
        out_ready   = ordy;
        flush       = fl;
        #1;
        chk("in_ready",  bundle_t'(in_ready),  bundle_t'(exp_lvl < 2));
        chk("out_valid", bundle_t'(out_valid), bundle_t'(exp_lvl != 0));
        chk("level",     bundle_t'(level),     bundle_t'(exp_lvl));
        push = iv && (exp_lvl < 2);
        pop  = ordy && (exp_lvl != 0);
        if (fl) begin
            sb.delete();
            exp_lvl = 0;
        end else begin
            if (pop) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", bundle_t'(1), bundle_t'(0));
                end else begin
                    chk("pop_bundle", obs(), sb.pop_front());
                end
            end
            if (push) sb.push_back(e);
            exp_lvl = exp_lvl + (push ? 1 : 0) - (pop ? 1 : 0);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_ADDI = 32'hFF020293;
    localparam logic [31:0] I_BEQ  = 32'hFE208CE3;
    localparam logic [31:0] I_SW   = 32'h0020A423;
    localparam logic [31:0] I_LUI  = 32'h123453B7;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_SRAI = 32'h40315093;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_LOW  = 32'h00208192;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    bundle_t e_add, e_addi, e_beq, e_sw, e_lui, e_jal, e_srai, e_mul, e_low, e_ill;
    logic [31:0] s_ins [8];
    bundle_t     s_exp [8];

    initial begin
        e_add  = mk(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 1'b0, 3'd0, 1'b0);
        e_addi = mk(7'h13, 3'd0, 7'h00, 5'd4, 5'd0, 5'd5, 32'hFFFF_FFF0, 1'b1, 3'd1, 1'b0);
        e_beq  = mk(7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8, 1'b0, 3'd3, 1'b0);
        e_sw   = mk(7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'h0000_0008, 1'b1, 3'd2, 1'b0);
        e_lui  = mk(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd7, 32'h1234_5000, 1'b1, 3'd4, 1'b0);
        e_jal  = mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'h0000_0008, 1'b1, 3'd5, 1'b0);
        e_srai = mk(7'h13, 3'd5, 7'h20, 5'd2, 5'd0, 5'd1, 32'h0000_0403, 1'b1, 3'd1, 1'b0);
        e_mul  = mk(7'h33, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b0, 3'd7, 1'b1);
        e_low  = mk(7'h12, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b0, 3'd7, 1'b1);
        e_ill  = mk(7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b0, 3'd7, 1'b1);
        s_ins = '{I_ADDI, I_BEQ, I_SW, I_LUI, I_JAL, I_SRAI, I_MUL, I_LOW};
        s_exp = '{e_addi, e_beq, e_sw, e_lui, e_jal, e_srai, e_mul, e_low};

        rst = 1'b1; instruction = 32'd0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #12;
        chk("rst_out_valid", bundle_t'(out_valid), bundle_t'(0));
        chk("rst_in_ready",  bundle_t'(in_ready),  bundle_t'(1));
        chk("rst_level",     bundle_t'(level),     bundle_t'(0));
        chk("rst_fields",    obs(),                bundle_t'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // add x3,x1,x2 visible on the following cycle
        tick(I_ADD, 1'b1, 1'b1, 1'b0, e_add);
        chk("add_head", obs(), e_add);

        // back-to-back stream with the consumer always ready
        for (int k = 0; k < 8; k++) tick(s_ins[k], 1'b1, 1'b1, 1'b0, s_exp[k]);
        for (int k = 0; k < 4 && exp_lvl != 0; k++) tick(32'd0, 1'b0, 1'b1, 1'b0, '0);

        // fill, hold the third, then drain in order
        tick(I_ADD,  1'b1, 1'b0, 1'b0, e_add);
        tick(I_ADDI, 1'b1, 1'b0, 1'b0, e_addi);
        tick(I_BEQ,  1'b1, 1'b0, 1'b0, e_beq);
        chk("full_stable_head", obs(), e_add);
        tick(I_BEQ,  1'b1, 1'b1, 1'b0, e_beq);
        tick(I_BEQ,  1'b1, 1'b1, 1'b0, e_beq);
        tick(32'd0,  1'b0, 1'b1, 1'b0, '0);
        tick(32'd0,  1'b0, 1'b1, 1'b0, '0);
        tick(32'd0,  1'b0, 1'b0, 1'b0, '0);

        // flush with a full queue and a pending input
        tick(I_ADD, 1'b1, 1'b0, 1'b0, e_add);
        tick(I_SW,  1'b1, 1'b0, 1'b0, e_sw);
        tick(I_LUI, 1'b1, 1'b0, 1'b1, e_lui);
        chk("flush_fields", obs(), bundle_t'(0));
        // flush at level 1 overrides a simultaneous push and pop
        tick(I_ADD, 1'b1, 1'b0, 1'b0, e_add);
        tick(I_SW,  1'b1, 1'b1, 1'b1, e_sw);
        tick(I_LUI, 1'b1, 1'b1, 1'b0, e_lui);
        tick(32'd0, 1'b0, 1'b1, 1'b0, '0);
        tick(32'd0, 1'b0, 1'b0, 1'b0, '0);

        // illegal entry at the head, then asynchronous reset mid-queue
        tick(I_ILL, 1'b1, 1'b0, 1'b0, e_ill);
        tick(I_ADD, 1'b1, 1'b0, 1'b0, e_add);
        chk("illegal_head", obs(), e_ill);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", bundle_t'(out_valid), bundle_t'(0));
        chk("async_rst_level",     bundle_t'(level),     bundle_t'(0));
        chk("async_rst_fields",    obs(),                bundle_t'(0));
        sb.delete();
        exp_lvl = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tick(I_JAL, 1'b1, 1'b1, 1'b0, e_jal);
        tick(32'd0, 1'b0, 1'b1, 1'b0, '0);
        tick(32'd0, 1'b0, 1'b0, 1'b0, '0);
        chk("sb_drained", bundle_t'(sb.size()), bundle_t'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered RV32I instruction decoder with a parametrised FIFO of decoded bundles.
- Sits between fetch and execute.
- Decodes opcode, funct3, funct7, rs1, rs2 and rd for all base formats (R/I/S/B/U/J).
- Generates sign-extended immediates of width XLEN, classifies each instruction's format, flags illegal encodings, and decouples fetch from execute with valid/ready handshakes.

Parameters:
- XLEN, 32, width of the immediate output; legal values 32 or 64; the immediate is sign-extended to XLEN.
- DEPTH, 2, number of decoded entries buffered; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- instruction  in  32  raw instruction word.
- in_valid  in  1  instruction is presented.
- in_ready  out  1  queue can accept an instruction.
- flush  in  1  synchronous discard of all queued entries.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes the head entry.
- opcode  out  7  instruction[6:0].
- funct3  out  3  decoded funct3.
- funct7  out  7  decoded funct7.
- rs1  out  5  source register 1.
- rs2  out  5  source register 2.
- rd  out  5  destination register.
- imm  out  XLEN  sign-extended immediate.
- alu_src  out  1  ALU operand B select: 0 = register, 1 = immediate.
- fmt  out  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=ILLEGAL.
- illegal  out  1  head entry is an illegal encoding.
- level  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (asynchronous, active-high):
  - Read pointer, write pointer and level clear to 0.
  - out_valid=0; in_ready=1.
  - All decoded field outputs drive 0 while out_valid=0.
- Handshakes:
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready = (level < DEPTH). There is no pass-through when full, even if out_ready=1.
  - out_valid = (level != 0).
  - Outputs are the head entry, driven from registers. They are stable while out_valid && !out_ready.
- Latency: an instruction pushed in cycle N is visible at the outputs in cycle N+1 at the earliest.
- Simultaneous push and pop: level is unchanged. This is legal at any level from 1 to DEPTH-1.
- Full: in_valid is ignored and no push occurs.
- Empty: out_ready is ignored.
- Pointers wrap modulo DEPTH.
- flush:
  - Pointers and level clear on the next edge.
  - Flush overrides a simultaneous push and pop; the incoming instruction is dropped.
  - in_ready remains as computed before the flush edge.
- Decode: performed combinationally on the input and stored per entry.
  - R (0110011): all fields taken from the instruction; imm=0; alu_src=0.
  - I (0010011, 0000011, 1100111, 1110011):
    - rs2=0.
    - funct7 = instruction[31:25] only for opcode 0010011 with funct3 of 001 or 101; otherwise funct7=0.
    - imm = sext(instruction[31:20]); alu_src=1.
  - S (0100011): rd=0; funct7=0; imm = sext({[31:25],[11:7]}); alu_src=1.
  - B (1100011): rd=0; funct7=0; imm = sext({[31],[7],[30:25],[11:8],0}); alu_src=0.
  - U (0110111, 0010111): rs1=rs2=funct3=funct7=0; imm = sext({[31:12],12'b0}); alu_src=1.
  - J (1101111): rs1=rs2=funct3=funct7=0; imm = sext({[31],[19:12],[20],[30:21],0}); alu_src=1.
- Illegal encodings: any other opcode, an R-type funct7 other than 0000000 or 0100000, or instruction[1:0] != 11.
  - Result: fmt=7, illegal=1, and every other field is 0 except opcode.
  - Illegal entries are still enqueued and popped normally.
- Reset mid-operation: all queued entries are lost immediately; no partial outputs.

Optional Feature:
- Macro DECODE_QUEUE_STATS_EN.
- Defined:
  - Adds output retired_cnt (32 bits) and illegal_cnt (16 bits).
  - Both increment on every pop; illegal_cnt only when the popped entry has illegal=1.
  - Both saturate at all-ones.
  - Both are cleared by rst only, not by flush.
- Undefined: these ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Push 0x002081B3 (add x3,x1,x2) with out_ready=1:
  - Next cycle: out_valid=1, opcode=0110011, rs1=1, rs2=2, rd=3, funct7=0, imm=0, fmt=0, alu_src=0.
- Push 0xFF020293 (addi x5,x4,-16) with XLEN=32: rs1=4, rd=5, rs2=0, funct3=0, imm=0xFFFFFFF0, fmt=1, alu_src=1.
- Push 0xFE208CE3 (beq x1,x2,-8): rs1=1, rs2=2, rd=0, imm=0xFFFFFFF8, fmt=3.
- DEPTH=2, out_ready=0, three pushes:
  - in_ready falls after the second push; level=2; the third instruction is held.
  - Raise out_ready: the entries pop in order, then the third is accepted.
- Queue holds 2 entries; assert flush together with in_valid: the next cycle has level=0, out_valid=0, and the input was not enqueued.
- Push 0x0000007F: illegal=1, fmt=7, all fields except opcode are 0.
  - Then assert rst asynchronously mid-queue: out_valid drops immediately and level=0.
